// File: rtl/fpgapu_pkg.sv
// Shared audio-core definitions: song ROM geometry and note/order word layouts
// used by the pattern sequencers and the ROM arbiter.
package fpgapu_pkg;

  localparam int ROM_ADDR_W = 8;
  localparam int ROM_DATA_W = 16;

  localparam int NOTE_PITCH_LSB = 0;
  localparam int NOTE_PITCH_W   = 6;
  localparam int NOTE_LEN_LSB   = 6;
  localparam int NOTE_LEN_W     = 5;
  localparam int NOTE_INST_LSB  = 11;
  localparam int NOTE_INST_W    = 4;

  localparam int ORDER_PADDR_LSB = 0;
  localparam int ORDER_PADDR_W   = 8;
  localparam int ORDER_PLEN_LSB  = 8;
  localparam int ORDER_PLEN_W    = 8;

  // Bit 15 of a note word is reserved.
  typedef struct packed {
    logic                   rsvd;
    logic [NOTE_INST_W-1:0] instrument;
    logic [NOTE_LEN_W-1:0]  length;
    logic [NOTE_PITCH_W-1:0] pitch;
  } note_word_t;

  typedef struct packed {
    logic [ORDER_PLEN_W-1:0]  pat_len;
    logic [ORDER_PADDR_W-1:0] pat_addr;
  } order_word_t;

endpackage

// File: rtl/song_rom_arbiter_if.sv
// Channel-side request/grant/response bundle between the pattern sequencers
// and the song ROM arbiter.
interface song_rom_arbiter_if
  import fpgapu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W
);
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*ADDR_W-1:0] i_addr;
  logic [NUM_REQ-1:0]        o_gnt;
  logic [NUM_REQ-1:0]        o_rvalid;
  logic [DATA_W-1:0]         o_rdata;

  modport master (output i_req, i_addr, input o_gnt, o_rvalid, o_rdata);
  modport slave  (input i_req, i_addr, output o_gnt, o_rvalid, o_rdata);
endinterface

// File: rtl/song_rom_arbiter_rr_priority_encoder.sv
// Circular find-first-set starting at ptr; yields a one-hot grant and its index.
module rr_priority_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // Bits below ptr are masked in the low copy only; the upper copy then
  // supplies the wrapped-around candidates, so a single isolate-lowest-set
  // covers the whole circular search.
  always_comb begin
    dbl    = {req, req};
    masked = dbl & ({(2*N){1'b1}} << ptr);
    first  = masked & (~masked + {{(2*N-1){1'b0}}, 1'b1});
    gnt    = first[N-1:0] | first[2*N-1:N];
  end

  always_comb begin
    idx = '0;
    for (int unsigned k = 0; k < unsigned'(N); k++) begin
      if (gnt[k]) idx = IDX_W'(k);
    end
  end

endmodule

// File: rtl/song_rom_arbiter.sv
// Round-robin (or fixed-priority) sharing of the synchronous song ROM between
// NUM_REQ sequencer channels; read data returns one cycle after the grant.
module song_rom_arbiter
  import fpgapu_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = ROM_ADDR_W,
  parameter int DATA_W      = ROM_DATA_W,
  parameter int ROUND_ROBIN = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  song_rom_arbiter_if.slave  chan,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [DATA_W-1:0]  i_rom_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   enc_ptr;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] enc_gnt;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rv_q;
  logic [ADDR_W-1:0]  addr_mux;
  logic               any_gnt;

  assign enc_ptr = (ROUND_ROBIN != 0) ? ptr : '0;

  rr_priority_encoder #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_enc (
    .req (chan.i_req),
    .ptr (enc_ptr),
    .gnt (enc_gnt),
    .idx (win_idx)
  );

  always_comb begin
    gnt     = i_rst_n ? enc_gnt : '0;
    any_gnt = |gnt;
    ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
  end

  // AND-OR mux keyed on the one-hot grant: zero address when nothing is granted.
  always_comb begin
    addr_mux = '0;
    for (int unsigned k = 0; k < unsigned'(NUM_REQ); k++) begin
      if (gnt[k]) addr_mux = addr_mux | chan.i_addr[k*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr  <= '0;
      rv_q <= '0;
    end else begin
      rv_q <= gnt;
      if (any_gnt) ptr <= ptr_nxt;
    end
  end

  assign chan.o_gnt    = gnt;
  assign chan.o_rvalid = rv_q;
  assign chan.o_rdata  = i_rom_data;
  assign o_rom_addr    = addr_mux;

endmodule

// File: doc/song_rom_arbiter.md
# song_rom_arbiter

Shares the single synchronous-read song ROM between `NUM_REQ` pattern-sequencer channels. Each channel raises a read request with an address. The arbiter grants one request per cycle in round-robin order, drives the ROM address, and routes the returned 16-bit word back to the granted channel one cycle later. It sits between the per-channel sequencers and the ROM instance in the audio top level, so the sequencers need no changes beyond gaining a req/gnt handshake.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting channels (2..8).
- `ADDR_W`, 8: ROM address width.
- `DATA_W`, 16: ROM data width.
- `ROUND_ROBIN`, 1: 1 = rotating priority; 0 = fixed priority (lowest index wins).

Ports:
- `i_clk`, in, 1: system clock; all logic on the rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_req`, in, `NUM_REQ`: per-channel read request, level.
- `i_addr`, in, `NUM_REQ*ADDR_W`: flattened per-channel addresses; channel k occupies `[k*ADDR_W +: ADDR_W]`.
- `o_gnt`, out, `NUM_REQ`: one-hot grant, combinational, same cycle as the request.
- `o_rvalid`, out, `NUM_REQ`: one-hot, registered; data for that channel is on `o_rdata` this cycle.
- `o_rdata`, out, `DATA_W`: shared read-data bus, equal to `i_rom_data`.
- `o_rom_addr`, out, `ADDR_W`: ROM address, combinational.
- `i_rom_data`, in, `DATA_W`: ROM output; valid one cycle after the address.

## Operation
- **Priority pointer** `ptr` (`$clog2(NUM_REQ)` bits) names the highest-priority channel.
  - The granted channel is the first k with `i_req[k]`=1, searched circularly from `ptr`.
  - `ROUND_ROBIN`=0: the search always starts at 0 and `ptr` is unused.
- **Grant cycle:**
  - `o_gnt[k]`=1 and `o_rom_addr` = channel k's address.
  - `ptr` loads (k+1) mod `NUM_REQ` at the clock edge.
  - `rv_q` loads the one-hot grant at the clock edge.
- **No request:**
  - `o_gnt`=0 and `o_rom_addr`=0.
  - `ptr` holds; `rv_q` loads 0.
- **Response:** `o_rvalid` = `rv_q`. `o_rdata` is meaningful only while some `o_rvalid` bit is set.
- **Handshake rules:**
  - A requester holds `i_req` and its address stable until it sees its `o_gnt` bit.
  - It may drop `i_req` before being granted, with no side effects.
  - It may re-request in the cycle after its grant, or in the same cycle as its `o_rvalid`.
- **Boundary conditions:**
  - Throughput is one grant per cycle, back-to-back, with no bubbles.
  - A single requester held high is granted every cycle.
  - Pointer wrap: after channel `NUM_REQ`-1 is granted, `ptr`=0.
  - All channels requesting continuously are granted in order `ptr`, `ptr`+1, … with no channel skipped. Worst-case wait is `NUM_REQ`-1 cycles.
  - A request arriving in the same cycle as another channel's response has no conflict, because the address and data phases are independent.
- **Reset:**
  - Asynchronous assertion clears `ptr` to 0 and `rv_q` to 0 immediately.
  - While `i_rst_n`=0, `o_gnt` is forced to 0 and `o_rom_addr` to 0.
  - An in-flight read is dropped and its `o_rvalid` never appears.
  - Reset values: `o_gnt`=0, `o_rvalid`=0, `o_rom_addr`=0, `o_rdata`=`i_rom_data` (don't-care).

## Timing
- **Cycle N:** `i_req[k]`=1, k wins, `o_gnt[k]`=1, `o_rom_addr`=addr_k.
- **Cycle N+1:** `o_rvalid[k]`=1, `o_rdata`=ROM[addr_k].
- **Latency:** request to data is 1 cycle when uncontested, and 1+wait cycles otherwise.
- **Critical path:** `i_req` → rotate/priority-encode → address mux → ROM address register. Keep the encoder a shallow mask-and-find-first.
- **Reset release:** deassertion must be synchronised externally to `i_clk`. The first possible grant is in the first cycle with `i_rst_n`=1.

## Structure
- **Shared package `fpgapu_pkg`:**
  - `ROM_ADDR_W`=8 and `ROM_DATA_W`=16.
  - Note-word field positions: pitch [5:0], length [10:6], instrument [14:11].
  - Order-word field positions: pattern address [7:0], pattern length [15:8].
  - The sequencers and the arbiter both use these.
- **Sub-module `rr_priority_encoder`:**
  - Combinational, parameterised by N.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and binary index.
  - Implementation: double-width mask trick.
- **Top module contents:** `ptr`, `rv_q`, the address mux and reset gating.

## Test plan
- **Reset:** drive `i_rst_n`=0 with all `i_req`=1 → `o_gnt`=0, `o_rom_addr`=0, `o_rvalid`=0. Release reset → the first grant goes to channel 0.
- **Single channel:** `NUM_REQ`=4, channel 2 requests addr 8'h10, ROM[0x10]=16'hA5C3. Expect `o_gnt`=4'b0100 with `o_rom_addr`=8'h10, then next cycle `o_rvalid`=4'b0100 and `o_rdata`=16'hA5C3.
- **Contention:** all 4 channels request continuously with addrs 0x00/0x01/0x02/0x03. Expect grants 0,1,2,3,0,1 on consecutive cycles, with each `o_rvalid` one cycle later carrying the matching ROM word.
- **Wrap and withdrawal:** with `ptr`=3, channel 3 drops its request before grant while channels 0 and 1 request. Expect grant to channel 0, then `ptr`=1, then grant to channel 1.
- **Reset mid-read:** grant channel 1, then assert `i_rst_n`=0 in the following cycle. Expect `o_rvalid` to stay 0 and `ptr`=0.
- **Fixed priority:** `ROUND_ROBIN`=0 with channels 1 and 3 requesting for 3 cycles. Expect channel 1 granted every cycle and channel 3 never granted.
